// File: rtl/draw_card_ctrl.sv
// draw_card_ctrl: places one drawn card into the lowest empty hand slot.
// Ports: clk/rst/interboard_rst, map (flat slot bus), draw_req/draw_card
// (request), busy, map_wr_en/addr/data (write port), draw_done/draw_fail
// (result pulses), card_place (slot of the last successful draw).
module draw_card_ctrl #(
  parameter int HAND_SLOTS = 36,
  parameter int NO_CARD    = 54,
  parameter int MAP_SLOTS  = 144
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   interboard_rst,
  input  logic [MAP_SLOTS*6-1:0] map,
  input  logic                   draw_req,
  input  logic [5:0]             draw_card,
  output logic                   busy,
  output logic                   map_wr_en,
  output logic [7:0]             map_wr_addr,
  output logic [5:0]             map_wr_data,
  output logic                   draw_done,
  output logic                   draw_fail,
  output logic [5:0]             card_place
);

  localparam int MAP_W = MAP_SLOTS * 6;
  localparam int AW    = $clog2(MAP_W);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WRITE,
    FAIL
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [5:0] card_q, card_d;
  logic       busy_q, busy_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [5:0] wr_data_q, wr_data_d;
  logic       done_q, done_d;
  logic       fail_q, fail_d;
  logic [5:0] place_q, place_d;

  logic [AW-1:0] slot_base;
  logic [5:0]    slot;

  // slot 0 sits in the most significant 6 bits of the map bus
  always_comb begin
    slot_base = AW'(MAP_W - 1 - 6 * int'(idx_q));
    slot      = map[slot_base -: 6];
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    card_d    = card_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    fail_d    = 1'b0;
    place_d   = place_q;
    unique case (state_q)
      IDLE: begin
        if (draw_req) begin
          if (draw_card < 6'(NO_CARD)) begin
            card_d  = draw_card;
            idx_d   = '0;
            state_d = SCAN;
          end else begin
            state_d = FAIL;
          end
        end
      end
      SCAN: begin
        if (slot == 6'(NO_CARD)) begin
          state_d = WRITE;
        end else if (idx_q == 6'(HAND_SLOTS - 1)) begin
          state_d = FAIL;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      WRITE: begin
        wr_en_d   = 1'b1;
        wr_addr_d = 8'(idx_q);
        wr_data_d = card_q;
        done_d    = 1'b1;
        place_d   = idx_q;
        state_d   = IDLE;
      end
      FAIL: begin
        fail_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst || interboard_rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      card_q    <= '0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      place_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      card_q    <= card_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      place_q   <= place_d;
    end
  end

  assign busy        = busy_q;
  assign map_wr_en   = wr_en_q;
  assign map_wr_addr = wr_addr_q;
  assign map_wr_data = wr_data_q;
  assign draw_done   = done_q;
  assign draw_fail   = fail_q;
  assign card_place  = place_q;

endmodule

// File: tb/tb_draw_card_ctrl.sv
// tb_draw_card_ctrl: scoreboard bench for draw_card_ctrl.
// Stimulus predicts each draw outcome; a monitor compares DUT pulses.
module tb_draw_card_ctrl;

  localparam int HS    = 36;
  localparam int NC    = 54;
  localparam int MS    = 144;
  localparam int MAP_W = MS * 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             interboard_rst = 1'b0;
  logic [MAP_W-1:0] map;
  logic             draw_req = 1'b0;
  logic [5:0]       draw_card = '0;
  logic             busy;
  logic             map_wr_en;
  logic [7:0]       map_wr_addr;
  logic [5:0]       map_wr_data;
  logic             draw_done;
  logic             draw_fail;
  logic [5:0]       card_place;

  logic [5:0] slots [MS];

  typedef struct {
    bit         is_fail;
    logic [7:0] addr;
    logic [5:0] data;
    int         cyc;
    logic [5:0] place;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   misses = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  logic [5:0] model_place = '0;

  draw_card_ctrl #(
    .HAND_SLOTS(HS),
    .NO_CARD(NC),
    .MAP_SLOTS(MS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .interboard_rst(interboard_rst),
    .map(map),
    .draw_req(draw_req),
    .draw_card(draw_card),
    .busy(busy),
    .map_wr_en(map_wr_en),
    .map_wr_addr(map_wr_addr),
    .map_wr_data(map_wr_data),
    .draw_done(draw_done),
    .draw_fail(draw_fail),
    .card_place(card_place)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    map = '0;
    for (int i = 0; i < MS; i++)
      map[MAP_W-1-6*i -: 6] = slots[i];
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d",
               name, cyc, act, exp);
    end
  endtask

  // Reference: predicted outcome of a request sampled at edge t.
  task automatic predict(input logic [5:0] c, input int t, output int e);
    exp_t x;
    int k;
    k = -1;
    for (int i = 0; i < HS; i++)
      if (k < 0 && slots[i] == 6'(NC)) k = i;
    x.addr = '0;
    x.data = '0;
    if (c >= 6'(NC)) begin
      x.is_fail = 1;
      e = t + 1;
    end else if (k < 0) begin
      x.is_fail = 1;
      e = t + HS + 1;
    end else begin
      x.is_fail = 0;
      x.addr = 8'(k);
      x.data = c;
      e = t + 2 + k;
      model_place = 6'(k);
    end
    x.cyc = e;
    x.place = model_place;
    exp_q.push_back(x);
    busy_lo = t;
    busy_hi = e - 1;
  endtask

  // Called at a negedge with the DUT idle; drives a one-cycle request.
  task automatic issue(input logic [5:0] c, output int e);
    draw_req = 1'b1;
    draw_card = c;
    predict(c, cyc + 1, e);
    @(negedge clk);
    draw_req = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic fill_hand(input logic [5:0] v);
    for (int i = 0; i < MS; i++) slots[i] = (i < HS) ? v : 6'(NC);
  endtask

  task automatic do_reset_abort(input bit ib);
    if (ib) interboard_rst = 1'b1;
    else rst = 1'b1;
    exp_q.delete();
    busy_lo = 1;
    busy_hi = 0;
    model_place = '0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr_en", 32'(map_wr_en), 0);
    chk("rst_addr", 32'(map_wr_addr), 0);
    chk("rst_data", 32'(map_wr_data), 0);
    chk("rst_done", 32'(draw_done), 0);
    chk("rst_fail", 32'(draw_fail), 0);
    chk("rst_place", 32'(card_place), 0);
    rst = 1'b0;
    interboard_rst = 1'b0;
  endtask

  // Monitor: compares every pulse against the scoreboard queue.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        x = exp_q.pop_front();
        vectors++;
        misses++;
        $display("FAIL timeout @cyc %0d: no pulse, expected at %0d",
                 cyc, x.cyc);
      end
      if (map_wr_en || draw_done || draw_fail) begin
        if (exp_q.size() == 0) begin
          vectors++;
          misses++;
          $display("FAIL spurious @cyc %0d: wr_en=%0b done=%0b fail=%0b",
                   cyc, map_wr_en, draw_done, draw_fail);
        end else begin
          x = exp_q.pop_front();
          chk("pulse_cycle", 32'(cyc), 32'(x.cyc));
          chk("wr_en", 32'(map_wr_en), 32'(!x.is_fail));
          chk("done", 32'(draw_done), 32'(!x.is_fail));
          chk("fail", 32'(draw_fail), 32'(x.is_fail));
          if (!x.is_fail) begin
            chk("wr_addr", 32'(map_wr_addr), 32'(x.addr));
            chk("wr_data", 32'(map_wr_data), 32'(x.data));
          end
          chk("card_place", 32'(card_place), 32'(x.place));
        end
      end
      chk("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
    end
  end

  initial begin
    int e, t;
    fill_hand(6'(NC));
    repeat (3) @(negedge clk);
    chk("init_busy", 32'(busy), 0);
    chk("init_wr_en", 32'(map_wr_en), 0);
    chk("init_place", 32'(card_place), 0);
    rst = 1'b0;
    @(negedge clk);

    // empty hand, best case
    issue(6'd13, e);
    wait_cyc(e);
    slots[0] = 6'd13;

    // first empty at 5, slot 9 also empty
    @(negedge clk);
    fill_hand(6'd20);
    for (int i = 0; i < 5; i++) slots[i] = 6'(i);
    slots[5] = 6'(NC);
    slots[9] = 6'(NC);
    issue(6'd40, e);
    wait_cyc(e);

    // full hand
    @(negedge clk);
    fill_hand(6'd33);
    issue(6'd7, e);
    wait_cyc(e);

    // invalid codes
    fill_hand(6'(NC));
    @(negedge clk);
    issue(6'd54, e);
    wait_cyc(e);
    @(negedge clk);
    issue(6'd63, e);
    wait_cyc(e);

    // reset during SCAN at idx 10
    @(negedge clk);
    fill_hand(6'd1);
    slots[20] = 6'(NC);
    t = cyc + 1;
    issue(6'd9, e);
    wait_cyc(t + 10);
    do_reset_abort(1'b0);

    // inter-board reset in the WRITE cycle
    @(negedge clk);
    t = cyc + 1;
    issue(6'd9, e);
    wait_cyc(e - 1);
    do_reset_abort(1'b1);
    repeat (5) @(negedge clk);

    // level-held request with map update after each write
    fill_hand(6'd20);
    slots[0] = 6'(NC);
    slots[1] = 6'(NC);
    draw_req = 1'b1;
    draw_card = 6'd11;
    t = cyc + 1;
    predict(6'd11, t, e);
    wait_cyc(t);
    draw_card = 6'd12;
    wait_cyc(e);
    slots[0] = 6'd11;
    predict(6'd12, e + 1, e);
    wait_cyc(e);
    draw_req = 1'b0;
    slots[1] = 6'd12;

    // pulse mid-scan is ignored
    @(negedge clk);
    fill_hand(6'd5);
    slots[20] = 6'(NC);
    t = cyc + 1;
    issue(6'd30, e);
    wait_cyc(t + 5);
    draw_req = 1'b1;
    draw_card = 6'd2;
    @(negedge clk);
    draw_req = 1'b0;
    wait_cyc(e);
    repeat (4) @(negedge clk);

    // randomized draws
    for (int n = 0; n < 40; n++) begin
      logic [5:0] c;
      bit full;
      full = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < MS; i++) begin
        if (i >= HS) slots[i] = 6'($urandom_range(0, 63));
        else if (!full && $urandom_range(0, 5) == 0) slots[i] = 6'(NC);
        else slots[i] = 6'($urandom_range(0, 53));
      end
      if ($urandom_range(0, 7) == 0) c = 6'($urandom_range(54, 63));
      else c = 6'($urandom_range(0, 53));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(c, e);
      wait_cyc(e);
      @(negedge clk);
    end

    repeat (50) @(negedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      misses++;
      $display("FAIL leftover: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule

// File: doc/draw_card_ctrl.md
Name: draw_card_ctrl

Overview:
- Sequences a single card draw into the current player's hand region of the game map.
- On a request it scans the hand slots one per cycle and finds the lowest-index empty slot (code NO_CARD).
- It then issues a one-cycle write of the drawn card into that slot and reports completion or failure.
- Sits between the game-control FSM (requester) and the map register file (write port owner).

Parameters:
- HAND_SLOTS, 36, number of hand slots scanned (slot indices 0..HAND_SLOTS-1)
- NO_CARD, 54, 6-bit code marking an empty slot; card codes 0..53 are valid
- MAP_SLOTS, 144, total 6-bit slots in the map bus (8*18)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- interboard_rst  in  1  synchronous active-high reset from the inter-board link; same effect as rst
- map  in  MAP_SLOTS*6  flat map; slot i occupies bits [MAP_SLOTS*6-1 - 6*i -: 6]
- draw_req  in  1  request pulse/level, sampled only in IDLE
- draw_card  in  6  card code to place, sampled with draw_req
- busy  out  1  high whenever state != IDLE
- map_wr_en  out  1  one-cycle write strobe to the map owner
- map_wr_addr  out  8  slot index written (0..HAND_SLOTS-1)
- map_wr_data  out  6  card code written
- draw_done  out  1  one-cycle pulse on a successful placement (coincides with map_wr_en)
- draw_fail  out  1  one-cycle pulse when the hand is full or the card code is invalid
- card_place  out  6  slot used by the last successful draw; held until the next success or reset

Behaviour:
- Reset (rst or interboard_rst high at a clk edge):
  - state goes to IDLE.
  - busy, map_wr_en, draw_done and draw_fail are 0.
  - map_wr_addr, map_wr_data, card_place and the scan index are 0; the latched card is 0.
  - Reset has priority over everything, including mid-scan or during WRITE; an aborted draw produces no write and no pulse.
- States are IDLE, SCAN, WRITE and FAIL; all outputs are registered.
- IDLE:
  - If draw_req=1 and draw_card<NO_CARD: latch draw_card, set idx=0, go to SCAN.
  - If draw_req=1 and draw_card>=NO_CARD: go to FAIL.
  - Otherwise stay in IDLE.
- SCAN, evaluated each cycle on slot idx of the map as currently presented:
  - If the slot equals NO_CARD: capture idx, go to WRITE.
  - Else if idx==HAND_SLOTS-1: go to FAIL.
  - Else idx<=idx+1.
  - idx never exceeds HAND_SLOTS-1, so there is no wrap-around.
- WRITE (exactly one cycle):
  - map_wr_en=1, map_wr_addr=captured idx, map_wr_data=latched card, draw_done=1.
  - card_place is updated to idx on entry.
  - Next state is IDLE.
- FAIL (exactly one cycle): draw_fail=1, no write, card_place unchanged; next state is IDLE.
- Latency, with the request sampled at edge T:
  - SCAN covers edges T+1..T+1+k for first empty slot k.
  - WRITE/draw_done are high during the cycle after edge T+2+k, so the best case is 2 cycles after the request.
  - Full hand: FAIL is entered at edge T+37 (HAND_SLOTS+1).
  - Invalid code: FAIL is entered at edge T+1.
- draw_req while busy is ignored and is not queued.
  - A level-held draw_req is re-sampled in the IDLE cycle following WRITE/FAIL and starts a new draw.
- The requester must hold map stable while busy; map changes during SCAN only affect slots not yet examined.
- Lowest empty index wins when several slots are empty.
- Only hand slots 0..HAND_SLOTS-1 are ever examined or written; slots HAND_SLOTS..MAP_SLOTS-1 are don't-care.

Test Plan:
- After reset, all slots hold 54 and draw_req is pulsed with card 13 → WRITE 2 cycles later: map_wr_en=1, addr=0, data=13, draw_done=1, card_place=0; busy high for 2 cycles.
- Slots 0..4 hold cards 0..4, slot 5 holds 54, slot 9 holds 54, request card 40 → exactly one write, addr=5, data=40, 7 cycles after the request; slot 9 is untouched.
- All 36 hand slots hold non-54 codes and slots 36..143 hold 54, request card 7 → draw_fail one pulse 37 cycles after the request, no map_wr_en, card_place unchanged.
- draw_card=54 or 63 with an empty hand → draw_fail the next cycle, no write, back in IDLE.
- Draw in progress on an empty hand at slot 20; rst asserted during SCAN at idx=10 → IDLE next edge, all outputs 0, no write; same check repeated with interboard_rst asserted in the WRITE cycle.
- draw_req held high continuously with slots 0,1 empty and the bench updating the map after each write → two back-to-back writes at addr 0 then 1; a draw_req pulse inserted mid-scan is ignored.
